// File: rtl/adc_sample_packer.sv
// ADC capture stage: arm/trigger gating, integer decimation, and packing of
// sample pairs into 24-bit words through a two-entry output buffer.
module adc_sample_packer #(
  parameter int pCOUNT_WIDTH = 20,
  parameter int pDECIM_WIDTH = 16
) (
  input  logic                    clk_adc,
  input  logic                    reset_n,
  input  logic [11:0]             adc_data,
  input  logic                    arm,
  input  logic                    trigger,
  input  logic [pDECIM_WIDTH-1:0] decimate,
  input  logic [pCOUNT_WIDTH-1:0] num_samples,
  output logic [23:0]             out_data,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    capturing,
  output logic                    done,
  output logic                    overflow,
  output logic [pCOUNT_WIDTH-1:0] sample_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_e;

  localparam logic [pCOUNT_WIDTH-1:0] CNT_ZERO = {pCOUNT_WIDTH{1'b0}};
  localparam logic [pCOUNT_WIDTH-1:0] CNT_ONE  = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pCOUNT_WIDTH-1:0] CNT_MAX  = {pCOUNT_WIDTH{1'b1}};
  localparam logic [pDECIM_WIDTH-1:0] DEC_ZERO = {pDECIM_WIDTH{1'b0}};
  localparam logic [pDECIM_WIDTH-1:0] DEC_ONE  = {{(pDECIM_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic                    arm_q, arm_d;
  logic [pDECIM_WIDTH-1:0] decim_q, decim_d, decim_cnt_q, decim_cnt_d;
  logic [pCOUNT_WIDTH-1:0] num_q, num_d, count_q, count_d;
  logic [11:0]             hold_q, hold_d;
  logic                    have_a_q, have_a_d;
  logic                    overflow_q, overflow_d;
  logic [23:0]             e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic                    e0_last_q, e0_last_d, e1_last_q, e1_last_d;
  logic [1:0]              fill_q, fill_d;
  logic                    valid_q, valid_d, capturing_q, capturing_d, done_q, done_d;
  logic                    push_s, push_last_s, pop_s, final_s, clr_ovf_s;
  logic [23:0]             push_data_s;

  // Capture state machine: sampling, decimation and pair packing
  always_comb begin
    state_d     = state_q;
    arm_d       = arm;
    decim_d     = decim_q;
    num_d       = num_q;
    decim_cnt_d = decim_cnt_q;
    count_d     = count_q;
    hold_d      = hold_q;
    have_a_d    = have_a_q;
    clr_ovf_s   = 1'b0;
    push_s      = 1'b0;
    push_last_s = 1'b0;
    push_data_s = 24'h000000;
    final_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm && !arm_q) begin
          state_d     = ARMED;
          clr_ovf_s   = 1'b1;
          count_d     = CNT_ZERO;
          decim_cnt_d = DEC_ZERO;
          hold_d      = 12'h000;
          have_a_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (!arm) begin
          state_d  = IDLE;
          have_a_d = 1'b0;
        end else if (trigger) begin
          decim_d = decimate;
          num_d   = num_samples;
          if (num_samples == CNT_ZERO) begin
            state_d = DONE;
          end else begin
            count_d     = CNT_ONE;
            decim_cnt_d = (decimate == DEC_ZERO) ? DEC_ZERO : DEC_ONE;
            if (num_samples == CNT_ONE) begin
              push_s      = 1'b1;
              push_data_s = {adc_data, 12'h000};
              push_last_s = 1'b1;
              have_a_d    = 1'b0;
              state_d     = DONE;
            end else begin
              hold_d   = adc_data;
              have_a_d = 1'b1;
              state_d  = CAPTURE;
            end
          end
        end else begin
          state_d = ARMED;
        end
      end
      CAPTURE: begin
        if (!arm) begin
          state_d  = IDLE;
          have_a_d = 1'b0;
        end else begin
          decim_cnt_d = (decim_cnt_q == decim_q) ? DEC_ZERO : decim_cnt_q + DEC_ONE;
          if (decim_cnt_q == DEC_ZERO) begin
            // count_q still holds the index of the sample being taken
            final_s = (count_q == num_q - CNT_ONE);
            count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_ONE;
            if (have_a_q) begin
              push_s      = 1'b1;
              push_data_s = {hold_q, adc_data};
              push_last_s = final_s;
              have_a_d    = 1'b0;
            end else if (final_s) begin
              push_s      = 1'b1;
              push_data_s = {adc_data, 12'h000};
              push_last_s = 1'b1;
            end else begin
              hold_d   = adc_data;
              have_a_d = 1'b1;
            end
            state_d = final_s ? DONE : CAPTURE;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      DONE: begin
        if (!arm) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-entry output buffer; entry 0 is the word presented downstream
  always_comb begin
    pop_s      = valid_q & out_ready;
    e0_data_d  = e0_data_q;
    e0_last_d  = e0_last_q;
    e1_data_d  = e1_data_q;
    e1_last_d  = e1_last_q;
    fill_d     = fill_q;
    overflow_d = clr_ovf_s ? 1'b0 : overflow_q;
    case (fill_q)
      2'd0: begin
        if (push_s) begin
          e0_data_d = push_data_s;
          e0_last_d = push_last_s;
          fill_d    = 2'd1;
        end else begin
          fill_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          e0_data_d = push_data_s;
          e0_last_d = push_last_s;
        end else if (push_s) begin
          e1_data_d = push_data_s;
          e1_last_d = push_last_s;
          fill_d    = 2'd2;
        end else if (pop_s) begin
          fill_d = 2'd0;
        end else begin
          fill_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          e0_data_d = e1_data_q;
          e0_last_d = e1_last_q;
          if (push_s) begin
            e1_data_d = push_data_s;
            e1_last_d = push_last_s;
          end else begin
            fill_d = 2'd1;
          end
        end else if (push_s) begin
          overflow_d = 1'b1;
        end else begin
          fill_d = 2'd2;
        end
      end
      default: fill_d = 2'd0;
    endcase
    valid_d     = (fill_d != 2'd0);
    capturing_d = (state_d == CAPTURE);
    done_d      = (state_d == DONE) && (fill_d == 2'd0);
  end

  // State and output registers
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      arm_q       <= 1'b0;
      decim_q     <= DEC_ZERO;
      num_q       <= CNT_ZERO;
      decim_cnt_q <= DEC_ZERO;
      count_q     <= CNT_ZERO;
      hold_q      <= 12'h000;
      have_a_q    <= 1'b0;
      overflow_q  <= 1'b0;
      e0_data_q   <= 24'h000000;
      e0_last_q   <= 1'b0;
      e1_data_q   <= 24'h000000;
      e1_last_q   <= 1'b0;
      fill_q      <= 2'd0;
      valid_q     <= 1'b0;
      capturing_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_q       <= arm_d;
      decim_q     <= decim_d;
      num_q       <= num_d;
      decim_cnt_q <= decim_cnt_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      have_a_q    <= have_a_d;
      overflow_q  <= overflow_d;
      e0_data_q   <= e0_data_d;
      e0_last_q   <= e0_last_d;
      e1_data_q   <= e1_data_d;
      e1_last_q   <= e1_last_d;
      fill_q      <= fill_d;
      valid_q     <= valid_d;
      capturing_q <= capturing_d;
      done_q      <= done_d;
    end
  end

  assign out_data     = e0_data_q;
  assign out_last     = e0_last_q;
  assign out_valid    = valid_q;
  assign capturing    = capturing_q;
  assign done         = done_q;
  assign overflow     = overflow_q;
  assign sample_count = count_q;
endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed and randomized bench for adc_sample_packer; expected words come
// from a sample-index model applied to the recorded adc_data stream.
module tb_adc_sample_packer;
  localparam int CW = 20;
  localparam int DW = 16;

  logic          clk_adc = 1'b0;
  logic          reset_n = 1'b0;
  logic [11:0]   adc_data = 12'h000;
  logic          arm = 1'b0;
  logic          trigger = 1'b0;
  logic [DW-1:0] decimate = '0;
  logic [CW-1:0] num_samples = '0;
  logic [23:0]   out_data;
  logic          out_last, out_valid, capturing, done, overflow;
  logic          out_ready = 1'b0;
  logic [CW-1:0] sample_count;

  int          n_pass = 0;
  int          n_total = 0;
  logic        ramp_mode = 1'b1;
  logic        rec = 1'b0;
  logic [11:0] ramp = 12'h000;
  logic [24:0] got[$];
  logic [11:0] stream[$];

  adc_sample_packer #(.pCOUNT_WIDTH(CW), .pDECIM_WIDTH(DW)) dut (
    .clk_adc(clk_adc), .reset_n(reset_n), .adc_data(adc_data), .arm(arm),
    .trigger(trigger), .decimate(decimate), .num_samples(num_samples),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .capturing(capturing), .done(done),
    .overflow(overflow), .sample_count(sample_count)
  );

  always #5 clk_adc = ~clk_adc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [24:0] word_at(input int i);
    return (got.size() > i) ? got[i] : 25'h1FFFFFF;
  endfunction

  // Sample at negedge, advance adc_data just after posedge
  task automatic cyc();
    @(negedge clk_adc);
    if (out_valid && out_ready) got.push_back({out_last, out_data});
    if (rec) stream.push_back(adc_data);
    @(posedge clk_adc);
    #1;
    if (ramp_mode) ramp = ramp + 12'd1;
    else ramp = 12'($urandom_range(0, 4095));
    adc_data = ramp;
  endtask

  task automatic capture(input int d, input int n, input bit rnd);
    logic [24:0] exp_q[$];
    int budget;
    out_ready = 1'b1;
    arm = 1'b1; decimate = DW'(d); num_samples = CW'(n);
    cyc();
    ramp_mode = !rnd;
    ramp = rnd ? 12'($urandom_range(0, 4095)) : 12'h005;
    adc_data = ramp;
    stream.delete(); got.delete();
    rec = 1'b1; trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    if (n >= 2) check("capturing_rise", 32'(capturing), 32'd1);
    if (n >= 2 && d == 0) begin
      cyc();
      check("pair_latency_valid", 32'(out_valid), 32'd1);
      check("pair_latency_data", 32'(out_data), 32'({stream[0], stream[1]}));
    end
    budget = 0;
    while (!done && budget < 200) begin
      cyc();
      budget++;
    end
    rec = 1'b0;
    check("done_reached", 32'(done), 32'd1);
    for (int i = 0; i < n; i += 2) begin
      logic [11:0] a, b;
      logic        last;
      a = stream[i * (d + 1)];
      b = (i + 1 < n) ? stream[(i + 1) * (d + 1)] : 12'h000;
      last = (i + 2 >= n);
      exp_q.push_back({last, a, b});
    end
    check("word_count", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) check("word", 32'(word_at(i)), 32'(exp_q[i]));
    check("sample_count", 32'(sample_count), 32'(n));
    check("no_overflow", 32'(overflow), 32'd0);
    check("capturing_low", 32'(capturing), 32'd0);
  endtask

  task automatic disarm();
    arm = 1'b0;
    cyc();
    cyc();
    check("idle_done_low", 32'(done), 32'd0);
  endtask

  initial begin
    int budget;
    repeat (2) @(posedge clk_adc);
    #1;
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_capturing", 32'(capturing), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_sample_count", 32'(sample_count), 32'd0);
    reset_n = 1'b1;
    cyc();

    capture(0, 4, 1'b0);
    check("basic_w0", 32'(word_at(0)), 32'h0005006);
    check("basic_w1", 32'(word_at(1)), 32'h1007008);
    disarm();

    capture(0, 3, 1'b0);
    check("odd_w1", 32'(word_at(1)), 32'h1007000);
    disarm();

    capture(2, 4, 1'b0);
    check("decim_w0", 32'(word_at(0)), 32'h0005008);
    check("decim_w1", 32'(word_at(1)), 32'h100B00E);
    disarm();

    // Backpressure: two words buffered, the rest dropped
    out_ready = 1'b0; ramp_mode = 1'b1;
    arm = 1'b1; decimate = '0; num_samples = CW'(8);
    cyc();
    ramp = 12'h005; adc_data = ramp; got.delete(); trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    repeat (12) cyc();
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_sample_count", 32'(sample_count), 32'd8);
    check("bp_done", 32'(done), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_hold_data", 32'(out_data), 32'h005006);
    out_ready = 1'b1;
    budget = 0;
    while (!done && budget < 20) begin
      cyc();
      budget++;
    end
    check("bp_done_after", 32'(done), 32'd1);
    check("bp_count", 32'(got.size()), 32'd2);
    check("bp_w0", 32'(word_at(0)), 32'h0005006);
    check("bp_w1", 32'(word_at(1)), 32'h0007008);
    arm = 1'b0; cyc();
    arm = 1'b1; cyc();
    check("rearm_clears_overflow", 32'(overflow), 32'd0);
    disarm();

    // Abort after three samples
    out_ready = 1'b1;
    arm = 1'b1; decimate = '0; num_samples = CW'(8);
    cyc();
    ramp = 12'h005; adc_data = ramp; got.delete(); trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    cyc(); cyc();
    arm = 1'b0;
    cyc();
    check("abort_capturing", 32'(capturing), 32'd0);
    check("abort_sample_count", 32'(sample_count), 32'd3);
    repeat (4) cyc();
    check("abort_words", 32'(got.size()), 32'd1);
    check("abort_w0", 32'(word_at(0)), 32'h0005006);
    check("abort_done", 32'(done), 32'd0);
    check("abort_drained", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-capture
    out_ready = 1'b0;
    arm = 1'b1; decimate = '0; num_samples = CW'(4);
    cyc();
    ramp = 12'h005; adc_data = ramp; trigger = 1'b1;
    cyc();
    trigger = 1'b0;
    cyc(); cyc();
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_capturing", 32'(capturing), 32'd0);
    check("arst_sample_count", 32'(sample_count), 32'd0);
    arm = 1'b0; out_ready = 1'b1;
    cyc();
    reset_n = 1'b1;
    cyc();
    capture(0, 4, 1'b0);
    check("post_rst_w0", 32'(word_at(0)), 32'h0005006);
    check("post_rst_w1", 32'(word_at(1)), 32'h1007008);
    disarm();

    // Randomized captures against the sample-index model
    for (int t = 0; t < 10; t++) begin
      capture(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), 1'b1);
      disarm();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/adc_sample_packer.md
# adc_sample_packer

Capture-path stage directly downstream of the ADC input DDR registers: takes the 12-bit sample presented every ADC feedback-clock cycle, gates capture on arm/trigger, applies integer decimation, and packs sample pairs into 24-bit words for the sample FIFO. A two-entry output buffer absorbs short backpressure stalls. Overflow is reported as a sticky flag.

## Interface
- pCOUNT_WIDTH, 20: width of num_samples and sample_count.
- pDECIM_WIDTH, 16: width of decimate.

- clk_adc  in  1  ADC feedback clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- adc_data  in  12  raw sample; new value every cycle.
- arm  in  1  level; capture enabled while high.
- trigger  in  1  level; starts capture while ARMED.
- decimate  in  pDECIM_WIDTH  keep 1 of every decimate+1 samples.
- num_samples  in  pCOUNT_WIDTH  samples to capture after trigger.
- out_data  out  24  {older sample, newer sample}.
- out_last  out  1  word holds final sample of capture.
- out_valid  out  1  word available.
- out_ready  in  1  downstream accepts word.
- capturing  out  1  state == CAPTURE.
- done  out  1  state == DONE and buffer empty.
- overflow  out  1  sticky: a word was dropped.
- sample_count  out  pCOUNT_WIDTH  samples taken this capture.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE. Reset state is IDLE.
- Inputs decimate and num_samples are sampled once, on the trigger edge.
- IDLE -> ARMED on arm rising edge, which needs a registered arm. That edge clears overflow, sample_count, the decimation counter and the pair-holding register.
- ARMED -> CAPTURE on the first edge with trigger=1. On that edge:
  - adc_data is taken as sample 0.
  - The decimation counter is set to 1, or to 0 if decimate=0.
  - If num_samples=0: go ARMED -> DONE and emit no words.
- CAPTURE sampling:
  - On each edge with decim_cnt==0, take adc_data and increment sample_count.
  - decim_cnt counts 0..decimate, then wraps to 0.
- Packing:
  - A first (even) sample is held in A.
  - The second sample B pushes {A,B}.
  - An odd final sample pushes {A,12'h000} with out_last=1.
  - The word containing sample num_samples-1 carries out_last=1.
- CAPTURE -> DONE on the edge that takes sample num_samples-1.
- DONE -> IDLE on arm=0.
- Abort: arm=0 in ARMED or CAPTURE -> IDLE.
  - A held partial sample is discarded.
  - Words already buffered still drain; no out_last is generated.
- Buffer: 2-entry FIFO.
  - out_valid = not empty.
  - Pop on out_valid && out_ready.
  - A push is accepted if the buffer is not full, or if a pop occurs on the same edge.
  - Otherwise the word is dropped and overflow is set. Capture and sample_count continue.
  - A dropped out_last word is lost; done still asserts once the buffer empties.
- Handshake rules:
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a pop, except on reset.
- Widths:
  - sample_count saturates at all-ones; it never wraps.
  - decim_cnt is pDECIM_WIDTH bits.

## Timing
- Reset values: out_data=0, out_last=0, out_valid=0, capturing=0, done=0, overflow=0, sample_count=0.
- Latency: B is on adc_data in cycle c; with the buffer empty, out_valid=1 with {A,B} in cycle c+1.
- capturing rises the cycle after trigger is seen in ARMED.
- Peak rate is 1 word per 2 cycles, so with out_ready held high the buffer never overflows.
- The first sample taken is the adc_data value present in the cycle trigger is first seen high in ARMED.
- Reset asserted mid-operation: all state clears immediately (asynchronous) and the buffer empties. The block resumes in IDLE on the first edge after reset_n rises.

## Test plan
- Basic capture: ramp adc_data 0x001,0x002,…, decimate=0, num_samples=4, out_ready=1, trigger seen with adc_data=0x005 -> words 0x005006, then 0x007008 with out_last=1. Then done=1 and sample_count=4.
- Odd count: same setup with num_samples=3 -> words 0x005006, then 0x007000 with out_last=1.
- Decimation: same ramp, decimate=2, num_samples=4 -> words 0x005008, then 0x00B00E with last=1.
- Backpressure: out_ready=0, num_samples=8 ->
  - Two words are buffered; words 3 and 4 are dropped.
  - overflow=1, sample_count=8, done=0.
  - Then out_ready=1 -> 0x005006 and 0x007008 are delivered, then done=1.
  - Re-arming clears overflow.
- Abort: drop arm after 3 samples -> IDLE, capturing=0, one word drains with no out_last, done=0.
- Async reset: pulse reset_n low mid-CAPTURE between clock edges -> all outputs are 0 immediately. A subsequent arm/trigger capture behaves as in the basic-capture scenario.
